// File: rtl/instruction_queue_if.sv
// ---------------------------------------------------------------------------
// instruction_queue_if
// Bundles the fetch-side (enqueue) and decode-side (dequeue) signals of the
// instruction queue.
//   master : fetch/decode environment (drives in_*, out_take)
//   slave  : the queue itself (drives in_ready, out_*, count, empty, full)
// Ports carried:
//   in_valid0/1, in_pc0/1, in_instr0/1, in_id0/1  - up to two fetched entries
//   in_ready                                      - >= 2 free entries
//   out_valid0/1, out_pc0/1, out_instr0/1, out_id0/1 - two oldest entries
//   out_take                                      - entries consumed (0..2)
//   count, empty, full                            - occupancy status
// ---------------------------------------------------------------------------
interface instruction_queue_if #(
    parameter int DEPTH = 8
);
    localparam int PTR_W = $clog2(DEPTH);

    logic              in_valid0;
    logic              in_valid1;
    logic [31:0]       in_pc0;
    logic [31:0]       in_pc1;
    logic [31:0]       in_instr0;
    logic [31:0]       in_instr1;
    logic [31:0]       in_id0;
    logic [31:0]       in_id1;
    logic              in_ready;

    logic              out_valid0;
    logic              out_valid1;
    logic [31:0]       out_pc0;
    logic [31:0]       out_pc1;
    logic [31:0]       out_instr0;
    logic [31:0]       out_instr1;
    logic [31:0]       out_id0;
    logic [31:0]       out_id1;
    logic [1:0]        out_take;

    logic [PTR_W:0]    count;
    logic              empty;
    logic              full;

    modport master (
        output in_valid0, in_valid1, in_pc0, in_pc1,
               in_instr0, in_instr1, in_id0, in_id1, out_take,
        input  in_ready, out_valid0, out_valid1, out_pc0, out_pc1,
               out_instr0, out_instr1, out_id0, out_id1,
               count, empty, full
    );

    modport slave (
        input  in_valid0, in_valid1, in_pc0, in_pc1,
               in_instr0, in_instr1, in_id0, in_id1, out_take,
        output in_ready, out_valid0, out_valid1, out_pc0, out_pc1,
               out_instr0, out_instr1, out_id0, out_id1,
               count, empty, full
    );
endinterface

// File: rtl/instruction_queue.sv
// ---------------------------------------------------------------------------
// instruction_queue
// Circular FIFO decoupling a dual-issue fetch stage from decode. Accepts up
// to two entries {pc, instr, id} per cycle, presents the two oldest entries,
// and lets decode consume 0, 1 or 2 per cycle. A flush empties the queue.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous, active-low reset
//   flush - discard all queued entries (priority over enqueue/dequeue)
//   q     - instruction_queue_if.slave (fetch inputs, decode outputs, status)
// ---------------------------------------------------------------------------
module instruction_queue #(
    parameter int DEPTH = 8
) (
    input logic               clk,
    input logic               rst,
    input logic               flush,
    instruction_queue_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    generate
        if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("instruction_queue: DEPTH must be a power of two >= 4");
        end
    endgenerate

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];
    logic [31:0] id_mem    [DEPTH];

    ptr_t       head;
    ptr_t       tail;
    cnt_t       cnt;

    ptr_t       head1;
    ptr_t       tail1;
    logic       ready;
    logic [1:0] take_lim;
    logic [1:0] enq;
    logic [1:0] deq;

    // Readiness is derived from the registered count only, so space freed
    // by this cycle's dequeue is never reused in the same cycle.
    always_comb begin
        head1 = head + ptr_t'(1);
        tail1 = tail + ptr_t'(1);
        ready = (cnt <= (DEPTH_C - cnt_t'(2)));

        if (flush || !ready || !q.in_valid0) begin
            enq = 2'd0;
        end else if (!q.in_valid1) begin
            enq = 2'd1;
        end else begin
            enq = 2'd2;
        end

        // Only two entries are ever presented, so an illegal take of 3 is
        // treated as 2 before the clamp against occupancy.
        take_lim = (q.out_take == 2'd3) ? 2'd2 : q.out_take;
        if (cnt_t'(take_lim) > cnt) begin
            deq = cnt[1:0];
        end else begin
            deq = take_lim;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= head + ptr_t'(deq);
            tail <= tail + ptr_t'(enq);
            cnt  <= cnt + cnt_t'(enq) - cnt_t'(deq);
        end
    end

    // Storage holds no reset: contents are only observed through count.
    always_ff @(posedge clk) begin
        if (enq != 2'd0) begin
            pc_mem[tail]    <= q.in_pc0;
            instr_mem[tail] <= q.in_instr0;
            id_mem[tail]    <= q.in_id0;
        end
        if (enq == 2'd2) begin
            pc_mem[tail1]    <= q.in_pc1;
            instr_mem[tail1] <= q.in_instr1;
            id_mem[tail1]    <= q.in_id1;
        end
    end

    always_comb begin
        q.out_valid0 = (cnt != '0);
        q.out_valid1 = (cnt >= cnt_t'(2));
        q.out_pc0    = '0;
        q.out_instr0 = '0;
        q.out_id0    = '0;
        q.out_pc1    = '0;
        q.out_instr1 = '0;
        q.out_id1    = '0;
        if (q.out_valid0) begin
            q.out_pc0    = pc_mem[head];
            q.out_instr0 = instr_mem[head];
            q.out_id0    = id_mem[head];
        end
        if (q.out_valid1) begin
            q.out_pc1    = pc_mem[head1];
            q.out_instr1 = instr_mem[head1];
            q.out_id1    = id_mem[head1];
        end
    end

    assign q.in_ready = ready;
    assign q.count    = cnt;
    assign q.empty    = (cnt == '0);
    assign q.full     = (cnt == DEPTH_C);

endmodule

// File: doc/instruction_queue.md
# instruction_queue

Decoupling buffer between the dual-issue instruction fetch stage and the decode stage. It accepts up to two fetched instructions per cycle (PC, word, instruction ID) into a circular FIFO and presents the two oldest entries to decode, which consumes 0, 1 or 2 per cycle. Fetch and decode stall independently, and a single-cycle flush discards all wrong-path instructions after a jump.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, >= 4
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  discard all queued entries
- in_valid0  in  1  slot-0 fetch entry valid (older)
- in_valid1  in  1  slot-1 fetch entry valid (younger); honoured only with in_valid0
- in_pc0, in_pc1  in  32  entry PCs
- in_instr0, in_instr1  in  32  instruction words
- in_id0, in_id1  in  32  instruction IDs
- in_ready  out  1  queue has >= 2 free entries
- out_valid0, out_valid1  out  1  head / head+1 entry present
- out_pc0, out_pc1  out  32  head / head+1 PC
- out_instr0, out_instr1  out  32  head / head+1 word
- out_id0, out_id1  out  32  head / head+1 ID
- out_take  in  2  entries consumed by decode this cycle (0, 1, 2; 3 is illegal)
- count  out  PTR_W+1  current occupancy
- empty  out  1  count == 0
- full  out  1  count == DEPTH

## Operation
- State: storage array[DEPTH] of {pc, instr, id}; head and tail pointers (PTR_W bits, natural wrap); count register.
- Enqueue count enq = 0 if !in_ready or !in_valid0 or flush; 1 if in_valid0 && !in_valid1; else 2. Slot 0 written at tail, slot 1 at tail+1 (mod DEPTH); tail advances by enq.
- Dequeue count deq = min(out_take, count); over-take (out_take > count, or out_take == 3) is clamped, not an error state. Head advances by deq.
- count_next = count + enq - deq; simultaneous enqueue and dequeue allowed in the same cycle.
- flush: head, tail, count cleared to 0; has priority over enqueue and dequeue in the same cycle; storage contents are don't-care.
- in_ready = (DEPTH - count) >= 2, from registered count only; does not depend on out_take this cycle (no same-cycle space reuse).
- Outputs combinational from storage and count: out_valid0 = count >= 1, out_valid1 = count >= 2; out_* fields read array[head] and array[head+1]. Fields with valid low driven to 0.
- No bypass: an entry written at edge N is visible on outputs after edge N.
- Ordering strictly preserved: out_id0 is always older than out_id1, in enqueue order.

## Timing
- Reset (rst low, asynchronous): head = tail = count = 0; in_ready = 1, empty = 1, full = 0, all out_valid = 0, all out_* data = 0. Release is synchronous to clk; first enqueue is accepted on the first edge after release.
- Fetch-to-decode latency: 1 cycle (enqueue at edge N, presented in cycle N+1).
- Throughput: sustained 2 in / 2 out per cycle once non-empty.
- Full boundary: count = DEPTH-1 or DEPTH gives in_ready = 0; fetch must hold its inputs. Offered entries are dropped silently when in_ready = 0.
- Empty boundary: out_take ignored when count = 0. out_take = 2 with count = 1 dequeues 1.
- Wrap-around: pointer arithmetic is modulo DEPTH. A 2-entry enqueue with tail = DEPTH-1 writes entries DEPTH-1 and 0.
- Flush in cycle N: outputs invalid from cycle N+1. Fetch entries presented in cycle N are discarded; entries in cycle N+1 are accepted normally.

## Test plan
- Reset: drive rst low mid-operation with count = 5 -> immediately count = 0, empty = 1, in_ready = 1, out_valid0/1 = 0, out_pc0 = 0.
- Dual enqueue then dual take: enqueue pc 0x3000/0x3004, id 0/1 -> next cycle out_valid0/1 = 1, out_pc0 = 0x3000, out_id1 = 1. out_take = 2 -> empty = 1.
- Fill: DEPTH = 8, four dual enqueues with no take -> count = 8, full = 1; in_ready = 0 from count = 7. A fifth offer is dropped and count stays 8.
- Wrap: advance head/tail to 7, enqueue ids 20/21 -> out_id0 = 20 and out_id1 = 21 across the wrap, read from slots 7 and 0.
- Flush with concurrent enqueue and take at count = 4 -> next cycle count = 0, no entry from that cycle's inputs appears.
- Over-take: count = 1, out_take = 3 -> count = 0, no underflow, head advanced by 1.
